harness_ctrl_driver: RTL
========================

HARNESS_CTRL_DRIVER -- requirements
Module: harness_ctrl_driver

Interface
REQ-001 Parameter AW, default 16, ctrl address width.
REQ-002 Parameter DW, default 32, ctrl data width.
REQ-003 Parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-004 Parameter TMO, default 15, read timeout in cycles (1..255).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 cmd_valid  in  1  host command strobe.
REQ-008 cmd_write  in  1  1=write, 0=read.
REQ-009 cmd_addr  in  AW  command address.
REQ-010 cmd_data  in  DW  write data (ignored for reads).
REQ-011 cmd_ready  out  1  FIFO not full; command accepted when cmd_valid & cmd_ready.
REQ-012 ctrl_ready, ctrl_write  out  1 each  transaction presented to dut.
REQ-013 ctrl_addr  out  AW; ctrl_data  out  DW  transaction address/data.
REQ-014 dut_cwait  in  1  dut stall; dut_cready  in  1  read data valid.
REQ-015 dut_data  in  DW  read data from dut.
REQ-016 rsp_valid  out  1  one-cycle read-response pulse.
REQ-017 rsp_data  out  DW; rsp_addr  out  AW; rsp_hit  out  1; rsp_timeout  out  1.
REQ-018 busy  out  1  FIFO non-empty or transaction in flight.

Function
REQ-019 Commands enqueue in order; a push with FIFO full is dropped, cmd_ready low while full.
REQ-020 States IDLE, ISSUE, DONE; IDLE->ISSUE when FIFO non-empty; ctrl_ready=1 only in ISSUE.
REQ-021 In ISSUE, ctrl_write/addr/data equal FIFO head and stay stable until completion.
REQ-022 Write completes in the first ISSUE cycle with dut_cwait=0; head popped that edge, no response.
REQ-023 Read completes in the first ISSUE cycle with dut_cwait=0; data/addr captured that edge, head popped.
REQ-024 On read completion rsp_hit=dut_cready, rsp_data=dut_cready ? dut_data : 0.
REQ-025 Read completion -> DONE for exactly one cycle with rsp_valid=1, rsp_* stable; DONE->ISSUE if FIFO non-empty else IDLE.
REQ-026 Write completion with FIFO non-empty stays in ISSUE, next head presented the following cycle (zero bubble).
REQ-027 Simultaneous push and pop in one cycle both take effect; count unchanged.
REQ-028 Push into empty FIFO: ctrl_ready asserts no earlier than the next cycle.
REQ-029 rsp_* outputs hold last value outside DONE; rsp_valid is 0 outside DONE.
REQ-030 busy = FIFO non-empty | state != IDLE.

Reset
REQ-031 On reset: FIFO empty, state IDLE, timeout counter 0, all outputs 0 except cmd_ready=1.
REQ-032 Reset during ISSUE or DONE drops ctrl_ready and rsp_valid on that edge; pending commands discarded, no response.

Configuration
REQ-033 Macro HARNESS_CTRL_TIMEOUT_EN defined: cycle counter runs during a read in ISSUE; when it reaches TMO with dut_cwait still 1, the read completes with rsp_timeout=1, rsp_hit=0, rsp_data=0, head popped.
REQ-034 HARNESS_CTRL_TIMEOUT_EN undefined: no counter, reads wait indefinitely, rsp_timeout tied 0.
REQ-035 Writes never time out in either configuration.

Structure
REQ-036 Package harness_pkg holds the state enum, default AW/DW, and response-on-timeout data constant (0).
REQ-037 Sub-module harness_cmd_fifo (synchronous FIFO, width 1+AW+DW, DEPTH entries, full/empty flags) holds the command queue.

Verification
REQ-038 Write 0x0010<-0xCAFEF00D, dut_cwait=0 -> ctrl_ready high one cycle with those values, no rsp_valid, busy falls the next cycle.
REQ-039 Read 0x0020, dut_cwait high 2 cycles then cready with data 0x12345678 -> ctrl_ready high 3 cycles, rsp_valid one cycle later, rsp_data=0x12345678, rsp_hit=1.
REQ-040 Push 5 commands with DEPTH=4, no pops -> fifth dropped, cmd_ready low after fourth; issue order is the first four.
REQ-041 TIMEOUT_EN, TMO=15, dut_cwait stuck 1 on a read -> rsp_valid after 15 ISSUE cycles, rsp_timeout=1, rsp_data=0; queued next command then issues.
REQ-042 Read with dut_cwait=0, dut_cready=0 -> rsp_valid, rsp_hit=0, rsp_data=0.
REQ-043 Reset asserted during a waiting read with 2 queued -> next cycle ctrl_ready=0, busy=0, no rsp_valid.

Source files
------------

// File: rtl/harness_pkg.sv
// rtl/harness_pkg.sv - shared types and defaults for the harness control driver
package harness_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_AW = 16;
    localparam int DEFAULT_DW = 32;

    // Fill bit for rsp_data on a miss or a timed-out read
    localparam logic TIMEOUT_DATA_BIT = 1'b0;

endpackage

// File: rtl/harness_cmd_fifo.sv
// rtl/harness_cmd_fifo.sv - synchronous command FIFO with full/empty flags and occupancy count
module harness_cmd_fifo #(
    parameter int W     = 49,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/harness_ctrl_driver.sv
// rtl/harness_ctrl_driver.sv - queued ctrl-bus transaction driver with read responses
// Optional read timeout enabled by defining HARNESS_CTRL_TIMEOUT_EN.
module harness_ctrl_driver
    import harness_pkg::*;
#(
    parameter int AW    = DEFAULT_AW,
    parameter int DW    = DEFAULT_DW,
    parameter int DEPTH = 4,
    parameter int TMO   = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_data,
    output logic          cmd_ready,
    output logic          ctrl_ready,
    output logic          ctrl_write,
    output logic [AW-1:0] ctrl_addr,
    output logic [DW-1:0] ctrl_data,
    input  logic          dut_cwait,
    input  logic          dut_cready,
    input  logic [DW-1:0] dut_data,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic [AW-1:0] rsp_addr,
    output logic          rsp_hit,
    output logic          rsp_timeout,
    output logic          busy
);
    localparam int FW = 1 + AW + DW;
    localparam int CW = $clog2(DEPTH) + 1;

    state_t        state;
    state_t        state_nx;
    logic [FW-1:0] head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          head_write;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic          tmo_hit;
    logic          complete;
    logic          more_after_pop;

    assign {head_write, head_addr, head_data} = head;

    harness_cmd_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cmd_valid),
        .push_data ({cmd_write, cmd_addr, cmd_data}),
        .pop       (complete),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef HARNESS_CTRL_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    // Fires on the TMO-th consecutive stalled cycle of a read
    assign tmo_hit = (state == ST_ISSUE) & ~head_write & dut_cwait & (tmo_cnt == 8'(TMO - 1));

    always_ff @(posedge clk) begin
        if (reset || state != ST_ISSUE || complete || head_write) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_timeout <= 1'b0;
        end else if (complete && !head_write) begin
            rsp_timeout <= tmo_hit;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    assign complete       = (state == ST_ISSUE) & (~dut_cwait | tmo_hit);
    // A same-cycle push keeps the queue non-empty, so a write can stream without a bubble
    assign more_after_pop = (fifo_count > CW'(1)) | (cmd_valid & ~fifo_full);
    assign cmd_ready      = ~fifo_full;
    assign busy           = ~fifo_empty | (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        ctrl_ready = 1'b0;
        ctrl_write = 1'b0;
        ctrl_addr  = '0;
        ctrl_data  = '0;
        rsp_valid  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                ctrl_ready = 1'b1;
                ctrl_write = head_write;
                ctrl_addr  = head_addr;
                ctrl_data  = head_data;
                if (complete) begin
                    if (!head_write) begin
                        state_nx = ST_DONE;
                    end else if (more_after_pop) begin
                        state_nx = ST_ISSUE;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                state_nx  = fifo_empty ? ST_IDLE : ST_ISSUE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_data <= '0;
            rsp_addr <= '0;
            rsp_hit  <= 1'b0;
        end else if (complete && !head_write) begin
            rsp_addr <= head_addr;
            rsp_hit  <= dut_cready & ~tmo_hit;
            rsp_data <= (dut_cready & ~tmo_hit) ? dut_data : {DW{TIMEOUT_DATA_BIT}};
        end
    end

endmodule
